// File: rtl/instr_encoder.sv
// MIPS instruction encoder: turns field requests into a stream of words.
// Optional macro ENCODER_RESERVED_CHECK_EN rejects op_kind=3 with err_o.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
    parameter int          DEPTH     = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        restart_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  op_kind_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [5:0]  funct_i,
    input  logic [15:0] imm_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_addr_o,
    output logic [10:0] count_o,
    output logic        full_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        FULL = 2'd2
    } state_t;

    localparam logic [10:0] DEPTH_W = 11'(DEPTH);

    state_t      state_q;
    logic [31:0] instr_q;
    logic [31:0] addr_q;
    logic [10:0] count_q;
    logic        valid_q;
    logic        full_q;
    logic        err_q;

    logic [31:0] enc_d;
    logic [10:0] count_inc;
    logic        rsv_rej;
    logic        accept;
    logic        xfer;

`ifdef ENCODER_RESERVED_CHECK_EN
    assign rsv_rej = (op_kind_i == 2'd3);
`else
    assign rsv_rej = 1'b0;
`endif

    // Field packing for the three supported opcodes; kind 3 becomes NOP.
    always_comb begin
        enc_d = 32'h0000_0000;
        unique case (op_kind_i)
            2'd0: enc_d = {6'h00, rs_i, rt_i, rd_i, shamt_i, funct_i};
            2'd1: enc_d = {6'h08, rs_i, rt_i, imm_i};
            2'd2: enc_d = {6'h0D, rs_i, rt_i, imm_i};
            default: enc_d = 32'h0000_0000;
        endcase
    end

    assign count_inc = count_q + 11'd1;

    // Ready in IDLE, or in HOLD when the held word leaves and room remains.
    always_comb begin
        req_ready_o = 1'b0;
        if (!reset && !restart_i) begin
            unique case (state_q)
                IDLE:    req_ready_o = 1'b1;
                HOLD:    req_ready_o = instr_ready_i && (count_inc < DEPTH_W);
                default: req_ready_o = 1'b0;
            endcase
        end
    end

    assign accept = req_valid_i && req_ready_o;
    assign xfer   = valid_q && instr_ready_i;

    // Control FSM with all outputs registered; reset beats restart.
    always_ff @(posedge clk) begin
        if (reset || restart_i) begin
            state_q <= IDLE;
            instr_q <= 32'h0000_0000;
            addr_q  <= BASE_ADDR;
            count_q <= 11'd0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= accept && rsv_rej;
            unique case (state_q)
                IDLE: begin
                    if (accept && !rsv_rej) begin
                        instr_q <= enc_d;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (xfer) begin
                        count_q <= count_inc;
                        addr_q  <= addr_q + 32'd4;
                        if (accept && !rsv_rej) begin
                            instr_q <= enc_d;
                        end else if (count_inc == DEPTH_W) begin
                            valid_q <= 1'b0;
                            full_q  <= 1'b1;
                            state_q <= FULL;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                FULL: begin
                    valid_q <= 1'b0;
                    full_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    full_q  <= 1'b0;
                end
            endcase
        end
    end

    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign instr_addr_o  = addr_q;
    assign count_o       = count_q;
    assign full_o        = full_q;

`ifdef ENCODER_RESERVED_CHECK_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder built with DEPTH=4.
// Expected words and addresses are hand-computed constants.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        restart_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  op_kind_i;
    logic [4:0]  rs_i, rt_i, rd_i, shamt_i;
    logic [5:0]  funct_i;
    logic [15:0] imm_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_addr_o;
    logic [10:0] count_o;
    logic        full_o;
    logic        err_o;

    int n_chk = 0;
    int n_bad = 0;

    localparam logic [31:0] BASE = 32'h0040_0000;

    instr_encoder #(.BASE_ADDR(BASE), .DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .restart_i    (restart_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .op_kind_i    (op_kind_i),
        .rs_i         (rs_i),
        .rt_i         (rt_i),
        .rd_i         (rd_i),
        .shamt_i      (shamt_i),
        .funct_i      (funct_i),
        .imm_i        (imm_i),
        .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i),
        .instr_o      (instr_o),
        .instr_addr_o (instr_addr_o),
        .count_o      (count_o),
        .full_o       (full_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic req(input logic [1:0] k, input logic [4:0] s,
                       input logic [4:0] t, input logic [4:0] d,
                       input logic [4:0] sh, input logic [5:0] fn,
                       input logic [15:0] im);
        req_valid_i = 1'b1;
        op_kind_i   = k;
        rs_i        = s;
        rt_i        = t;
        rd_i        = d;
        shamt_i     = sh;
        funct_i     = fn;
        imm_i       = im;
    endtask

    logic [31:0] held;

    initial begin
        reset = 1'b1;
        restart_i = 1'b0;
        instr_ready_i = 1'b1;
        req(2'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0);
        tick();
        tick();
        settle();
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_addr", instr_addr_o, BASE);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_full", 32'(full_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);

        reset = 1'b0;
        instr_ready_i = 1'b0;
        settle();
        chk("idle_ready", 32'(req_ready_o), 32'd1);
        tick();
        req_valid_i = 1'b0;
        chk("r_instr", instr_o, 32'h0022_1820);
        chk("r_addr", instr_addr_o, BASE);
        chk("r_valid", 32'(instr_valid_o), 32'd1);

        held = instr_o;
        req(2'd1, 5'd7, 5'd7, 5'd0, 5'd0, 6'h0, 16'h1234);
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("stall_ready", 32'(req_ready_o), 32'd0);
            tick();
            chk("stall_instr", instr_o, held);
            chk("stall_count", 32'(count_o), 32'd0);
        end
        req_valid_i = 1'b0;

        restart_i = 1'b1;
        settle();
        chk("rs_ready", 32'(req_ready_o), 32'd0);
        tick();
        restart_i = 1'b0;
        chk("rs_valid", 32'(instr_valid_o), 32'd0);
        chk("rs_count", 32'(count_o), 32'd0);

        instr_ready_i = 1'b1;
        req(2'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0005);
        tick();
        chk("addi_instr", instr_o, 32'h2008_0005);
        chk("addi_addr", instr_addr_o, BASE);
        req(2'd2, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h00FF);
        settle();
        chk("b2b_ready", 32'(req_ready_o), 32'd1);
        tick();
        chk("ori_instr", instr_o, 32'h3422_00FF);
        chk("ori_addr", instr_addr_o, BASE + 32'd4);
        chk("ori_valid", 32'(instr_valid_o), 32'd1);
        chk("ori_count", 32'(count_o), 32'd1);
        req_valid_i = 1'b0;
        tick();
        chk("two_count", 32'(count_o), 32'd2);
        chk("two_valid", 32'(instr_valid_o), 32'd0);
        chk("two_addr", instr_addr_o, BASE + 32'd8);

        req(2'd0, 5'd4, 5'd5, 5'd6, 5'd2, 6'h00, 16'h0);
        tick();
        chk("w3_instr", instr_o, 32'h0085_3080);
        req(2'd2, 5'd31, 5'd31, 5'd0, 5'd0, 6'h0, 16'hFFFF);
        settle();
        chk("w3_ready", 32'(req_ready_o), 32'd1);
        tick();
        chk("w4_instr", instr_o, 32'h37FF_FFFF);
        chk("w4_addr", instr_addr_o, BASE + 32'd12);
        chk("w4_count", 32'(count_o), 32'd3);
        settle();
        chk("w4_ready", 32'(req_ready_o), 32'd0);
        tick();
        chk("full_full", 32'(full_o), 32'd1);
        chk("full_valid", 32'(instr_valid_o), 32'd0);
        chk("full_count", 32'(count_o), 32'd4);
        chk("full_ready", 32'(req_ready_o), 32'd0);
        tick();
        chk("full_stay", 32'(full_o), 32'd1);
        chk("full_instr", instr_o, 32'h37FF_FFFF);
        req_valid_i = 1'b0;

        restart_i = 1'b1;
        tick();
        restart_i = 1'b0;
        settle();
        chk("rf_count", 32'(count_o), 32'd0);
        chk("rf_addr", instr_addr_o, BASE);
        chk("rf_full", 32'(full_o), 32'd0);
        chk("rf_ready", 32'(req_ready_o), 32'd1);

        req(2'd3, 5'd1, 5'd1, 5'd1, 5'd1, 6'h3F, 16'hFFFF);
        tick();
        req_valid_i = 1'b0;
`ifdef ENCODER_RESERVED_CHECK_EN
        chk("rsv_err", 32'(err_o), 32'd1);
        chk("rsv_valid", 32'(instr_valid_o), 32'd0);
        chk("rsv_count", 32'(count_o), 32'd0);
        tick();
        chk("rsv_err_off", 32'(err_o), 32'd0);
        chk("rsv_count2", 32'(count_o), 32'd0);
`else
        chk("nop_instr", instr_o, 32'h0);
        chk("nop_valid", 32'(instr_valid_o), 32'd1);
        chk("nop_err", 32'(err_o), 32'd0);
        tick();
        chk("nop_count", 32'(count_o), 32'd1);
        chk("nop_err2", 32'(err_o), 32'd0);
`endif

        instr_ready_i = 1'b1;
        req(2'd1, 5'd3, 5'd4, 5'd0, 5'd0, 6'h0, 16'h8000);
        tick();
        chk("pri_instr", instr_o, 32'h2064_8000);
        restart_i = 1'b1;
        req(2'd2, 5'd1, 5'd1, 5'd0, 5'd0, 6'h0, 16'h0001);
        tick();
        restart_i = 1'b0;
        req_valid_i = 1'b0;
        chk("pri_valid", 32'(instr_valid_o), 32'd0);
        chk("pri_count", 32'(count_o), 32'd0);
        chk("pri_addr", instr_addr_o, BASE);

        instr_ready_i = 1'b0;
        req(2'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0);
        tick();
        req_valid_i = 1'b0;
        chk("h_valid", 32'(instr_valid_o), 32'd1);
        reset = 1'b1;
        instr_ready_i = 1'b1;
        tick();
        reset = 1'b0;
        chk("hr_valid", 32'(instr_valid_o), 32'd0);
        chk("hr_count", 32'(count_o), 32'd0);
        chk("hr_addr", instr_addr_o, BASE);
        chk("hr_instr", instr_o, 32'h0);
        tick();
        chk("hr_count2", 32'(count_o), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0040_0000: byte address of the first emitted instruction.
REQ-002 Parameter DEPTH, default 64: number of instruction words accepted before the block reports full; legal range is 1 to 1024.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 restart_i  input  1  synchronous program restart.
REQ-006 req_valid_i  input  1  a request is present.
REQ-007 req_ready_o  output  1  the block accepts a request this cycle.
REQ-008 op_kind_i  input  2  operation kind: 0 = R-type, 1 = ADDI, 2 = ORI, 3 = reserved.
REQ-009 rs_i, rt_i, rd_i, shamt_i  input  5 each  register and shift fields.
REQ-010 funct_i  input  6  R-type function field.
REQ-011 imm_i  input  16  I-type immediate.
REQ-012 instr_valid_o  output  1  instr_o and instr_addr_o hold a word.
REQ-013 instr_ready_i  input  1  the downstream consumer takes the word.
REQ-014 instr_o  output  32  encoded MIPS instruction word.
REQ-015 instr_addr_o  output  32  byte address of instr_o.
REQ-016 count_o  output  11  number of words transferred since reset or restart.
REQ-017 full_o  output  1  DEPTH words have been transferred.
REQ-018 err_o  output  1  one-cycle pulse when a reserved request is rejected.

Function
REQ-019 Encoding SHALL follow the op_kind:
- R-type = {6'h00, rs, rt, rd, shamt, funct}
- ADDI = {6'h08, rs, rt, imm}
- ORI = {6'h0D, rs, rt, imm}
REQ-020 The state machine SHALL have three states: IDLE (no word held), HOLD (word held, instr_valid_o=1) and FULL (count_o == DEPTH).
REQ-021 A request SHALL be accepted when req_valid_i and req_ready_o are both 1.
REQ-022 Accept SHALL cause the encoded word to appear on instr_o, with instr_valid_o=1, on the next cycle (one-cycle latency); state goes to HOLD.
REQ-023 req_ready_o SHALL be 1 when restart_i=0 and either:
- the state is IDLE, or
- the state is HOLD, instr_ready_i=1 and count_o+1 < DEPTH.
It is 0 in all other cases.
REQ-024 In HOLD, instr_o and instr_addr_o SHALL stay stable until a transfer (instr_valid_o and instr_ready_i both 1).
REQ-025 On a transfer, count_o SHALL increment by 1, and instr_addr_o for the next word SHALL increment by 4.
REQ-026 After a transfer without a same-cycle accept, the next state SHALL be IDLE, or FULL if count_o reaches DEPTH.
REQ-027 A transfer and an accept in the same cycle SHALL load the new word back-to-back (state stays HOLD, one word per cycle sustained).
REQ-028 In FULL: req_ready_o=0, instr_valid_o=0 and full_o=1; only reset or restart_i leaves FULL.
REQ-029 restart_i SHALL, in the next cycle, set state=IDLE, count_o=0 and instr_addr_o=BASE_ADDR, and drop any held word; no transfer is counted in the restart cycle.
REQ-030 restart_i SHALL take priority over accept and transfer; reset SHALL take priority over restart_i.
REQ-031 instr_addr_o SHALL wrap modulo 2^32.

Reset
REQ-032 While reset=1 at a clock edge, the next cycle SHALL have:
- state=IDLE
- instr_valid_o=0
- instr_o=32'h0000_0000
- instr_addr_o=BASE_ADDR
- count_o=0
- full_o=0
- err_o=0
- req_ready_o=0 while reset is high
REQ-033 Reset asserted mid-HOLD SHALL discard the held word without a transfer.

Configuration
REQ-034 Macro ENCODER_RESERVED_CHECK_EN defined: an accepted op_kind=3 request produces no word, does not change count_o or state, and pulses err_o for exactly one cycle on the cycle after the accept.
REQ-035 Macro ENCODER_RESERVED_CHECK_EN undefined: err_o is tied to 0, and op_kind=3 is encoded as NOP 32'h0000_0000 and handled like any other word.

Verification
REQ-036 After reset, accept R-type rs=1, rt=2, rd=3, shamt=0, funct=6'h20 -> the next cycle shows instr_o=32'h0022_1820, instr_addr_o=32'h0040_0000, instr_valid_o=1.
REQ-037 ADDI rs=0, rt=8, imm=5, then ORI rs=1, rt=2, imm=16'h00FF, with instr_ready_i held at 1 -> back-to-back words 32'h2008_0005 @ 32'h0040_0000 and 32'h3422_00FF @ 32'h0040_0004; count_o=2.
REQ-038 Hold instr_ready_i=0 for 5 cycles with a word held -> instr_o stays constant, req_ready_o=0, count_o unchanged.
REQ-039 DEPTH=4, stream 4 words -> full_o=1 and req_ready_o=0; assert restart_i -> next cycle count_o=0, instr_addr_o=32'h0040_0000, req_ready_o=1.
REQ-040 With ENCODER_RESERVED_CHECK_EN defined, accept op_kind=3 -> err_o=1 for one cycle, instr_valid_o stays 0, count_o unchanged.
REQ-041 Assert reset while in HOLD -> next cycle instr_valid_o=0, count_o=0, no transfer observed.
